etb_tim_trig_router: RTL

Two-channel event-trigger router that sits between the dual-timer block's trigger outputs and its trigger-enable inputs. It consumes `tim1_etb_trig`, `tim2_etb_trig` and two external event lines. It produces the one-cycle `etb_tim*_trig_en_on/off` pulses that start and stop the timers. Routing, software triggers, hit counting and a sticky-status interrupt are programmed over an APB slave on the same `pclk` domain.

---
 rtl/etb_trig_pkg.sv | 53 +++++
 rtl/etb_tim_trig_router_if.sv | 12 +
 rtl/etb_trig_chan.sv | 47 ++++
 rtl/etb_tim_trig_router.sv | 98 +++++++++
 4 files changed

// File: rtl/etb_trig_pkg.sv
// Shared definitions for the ETB trigger router: register offsets, CTRL field
// layout and the source/destination encodings.
package etb_trig_pkg;

    localparam logic [7:0] ADDR_CH0_CTRL = 8'h00;
    localparam logic [7:0] ADDR_CH1_CTRL = 8'h04;
    localparam logic [7:0] ADDR_SWTRIG   = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h0C;
    localparam logic [7:0] ADDR_INTEN    = 8'h10;
    localparam logic [7:0] ADDR_CNT      = 8'h14;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_SRC_LSB = 1;
    localparam int unsigned CTRL_DST_LSB = 4;

    typedef enum logic [1:0] {
        SRC_TIM1 = 2'd0,
        SRC_TIM2 = 2'd1,
        SRC_EXT0 = 2'd2,
        SRC_EXT1 = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        DST_T1_ON  = 2'd0,
        DST_T1_OFF = 2'd1,
        DST_T2_ON  = 2'd2,
        DST_T2_OFF = 2'd3
    } dst_e;

    typedef struct packed {
        dst_e dst;
        src_e src;
        logic en;
    } ch_ctrl_t;

    function automatic ch_ctrl_t unpack_ctrl(input logic [31:0] w);
        ch_ctrl_t c;
        c.en  = w[CTRL_EN_BIT];
        c.src = src_e'(w[CTRL_SRC_LSB +: 2]);
        c.dst = dst_e'(w[CTRL_DST_LSB +: 2]);
        return c;
    endfunction

    function automatic logic [31:0] pack_ctrl(input ch_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]        = c.en;
        w[CTRL_SRC_LSB +: 2]  = c.src;
        w[CTRL_DST_LSB +: 2]  = c.dst;
        return w;
    endfunction

endpackage

// File: rtl/etb_tim_trig_router_if.sv
// APB slave bus of the ETB trigger router (no wait states, no error response).
interface etb_tim_trig_router_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/etb_trig_chan.sv
// One routing channel: source select, hit detection, wrapping hit counter,
// sticky status flag and one-hot destination request.
module etb_trig_chan
    import etb_trig_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  ch_ctrl_t         ctrl,
    input  logic [3:0]       rise,
    input  logic             swtrig,
    input  logic             status_clr,
    input  logic             cnt_clr,
    output logic [3:0]       dst_vec,
    output logic             status,
    output logic [CNT_W-1:0] count
);

    logic hit;

    // A simultaneous hardware rise and software trigger collapse into one hit.
    assign hit = ctrl.en & (rise[ctrl.src] | swtrig);

    always_comb begin
        dst_vec = '0;
        dst_vec[ctrl.dst] = hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= 1'b0;
            count  <= '0;
        end else begin
            if (hit)
                status <= 1'b1;
            else if (status_clr)
                status <= 1'b0;

            if (cnt_clr)
                count <= '0;
            else if (hit)
                count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/etb_tim_trig_router.sv
// Two-channel event-trigger router between the dual timer's trigger outputs
// and its trigger-enable inputs, programmed over APB.
module etb_tim_trig_router
    import etb_trig_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                   pclk,
    input  logic                   preset,
    etb_tim_trig_router_if.slave   apb,
    input  logic                   tim1_etb_trig,
    input  logic                   tim2_etb_trig,
    input  logic [1:0]             ext_trig,
    output logic                   etb_tim1_trig_en_on,
    output logic                   etb_tim1_trig_en_off,
    output logic                   etb_tim2_trig_en_on,
    output logic                   etb_tim2_trig_en_off,
    output logic                   intr
);

    logic [3:0]       src;
    logic [3:0]       src_q;
    logic [3:0]       rise;
    logic [3:0]       dst_q;
    logic [3:0]       dst_vec [2];
    ch_ctrl_t         ctrl [2];
    logic [1:0]       inten;
    logic [1:0]       status;
    logic [CNT_W-1:0] count [2];
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_data;

    assign src   = {ext_trig, tim2_etb_trig, tim1_etb_trig};
    assign rise  = src & ~src_q;
    assign wr_en = apb.psel & apb.penable & apb.pwrite;
    assign rd_en = apb.psel & ~apb.pwrite;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        etb_trig_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (pclk),
            .rst        (preset),
            .ctrl       (ctrl[g]),
            .rise       (rise),
            .swtrig     (wr_en && apb.paddr == ADDR_SWTRIG && apb.pwdata[g]),
            .status_clr (wr_en && apb.paddr == ADDR_STATUS && apb.pwdata[g]),
            .cnt_clr    (wr_en && apb.paddr == ADDR_CNT),
            .dst_vec    (dst_vec[g]),
            .status     (status[g]),
            .count      (count[g])
        );
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            src_q   <= '0;
            dst_q   <= '0;
            ctrl[0] <= '0;
            ctrl[1] <= '0;
            inten   <= '0;
        end else begin
            src_q <= src;
            dst_q <= dst_vec[0] | dst_vec[1];
            if (wr_en) begin
                case (apb.paddr)
                    ADDR_CH0_CTRL: ctrl[0] <= unpack_ctrl(apb.pwdata);
                    ADDR_CH1_CTRL: ctrl[1] <= unpack_ctrl(apb.pwdata);
                    ADDR_INTEN:    inten   <= apb.pwdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (apb.paddr)
            ADDR_CH0_CTRL: rd_data = pack_ctrl(ctrl[0]);
            ADDR_CH1_CTRL: rd_data = pack_ctrl(ctrl[1]);
            ADDR_STATUS:   rd_data[1:0] = status;
            ADDR_INTEN:    rd_data[1:0] = inten;
            ADDR_CNT: begin
                rd_data[CNT_W-1:0]  = count[0];
                rd_data[16 +: CNT_W] = count[1];
            end
            default: ;
        endcase
    end

    assign apb.prdata = rd_en ? rd_data : '0;

    assign etb_tim1_trig_en_on  = dst_q[DST_T1_ON];
    assign etb_tim1_trig_en_off = dst_q[DST_T1_OFF];
    assign etb_tim2_trig_en_on  = dst_q[DST_T2_ON];
    assign etb_tim2_trig_en_off = dst_q[DST_T2_OFF];
    assign intr = |(status & inten);

endmodule
